// File: rtl/uart_rx_core.sv
// Asynchronous serial receiver: synchronises rx, frames start/data/parity/stop
// bits and holds the last byte in a read register with status flags.
module uart_rx_core #(
  parameter int unsigned BAUD_DIV   = 868,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  input  logic                 rd_ack,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_rdy,
  output logic                 perr,
  output logic                 ferr,
  output logic                 ovf,
  output logic                 busy
);

  localparam int unsigned BCW = $clog2(BAUD_DIV);
  localparam int unsigned NCW = $clog2(DATA_BITS + 1);

  localparam logic [BCW-1:0] HALF_LOAD = BCW'(BAUD_DIV / 2 - 1);
  localparam logic [BCW-1:0] FULL_LOAD = BCW'(BAUD_DIV - 1);
  localparam logic [NCW-1:0] LAST_BIT  = NCW'(DATA_BITS - 1);
  localparam logic           HAS_PAR   = (PARITY_EN != 0);
  localparam logic           ODD       = (PARITY_ODD != 0);

  if (BAUD_DIV < 4) begin : g_bad_baud
    $error("uart_rx_core: BAUD_DIV must be at least 4");
  end
  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_bits
    $error("uart_rx_core: DATA_BITS must be in 5..8");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } state_t;

  state_t               state;
  logic [BCW-1:0]       baud_cnt;
  logic [NCW-1:0]       bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_err;

  logic       rx_meta;
  logic       rx_s;
  logic       rx_d;
  logic [2:0] sync_vld;
  logic       armed;
  logic       start_edge;

  // The sync flops reset high, so rx_d only reflects the real line once
  // sync_vld[2] is set; a line held low out of reset never arms the detector.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta  <= 1'b1;
      rx_s     <= 1'b1;
      rx_d     <= 1'b1;
      sync_vld <= 3'b000;
      armed    <= 1'b0;
    end else begin
      rx_meta  <= rx;
      rx_s     <= rx_meta;
      rx_d     <= rx_s;
      sync_vld <= {sync_vld[1:0], 1'b1};
      if (sync_vld[2] && rx_d) begin
        armed <= 1'b1;
      end
    end
  end

  assign start_edge = armed && !rx_s && rx_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_err  <= 1'b0;
      rx_data  <= '0;
      rx_rdy   <= 1'b0;
      perr     <= 1'b0;
      ferr     <= 1'b0;
      ovf      <= 1'b0;
      busy     <= 1'b0;
    end else begin
      // Host read; a load in the same cycle overrides this further down.
      if (rd_ack && rx_rdy) begin
        rx_rdy <= 1'b0;
        ovf    <= 1'b0;
      end

      unique case (state)
        IDLE: begin
          if (start_edge) begin
            state    <= START;
            baud_cnt <= HALF_LOAD;
            bit_cnt  <= '0;
            busy     <= 1'b1;
          end
        end

        START: begin
          if (baud_cnt != '0) begin
            baud_cnt <= baud_cnt - 1'b1;
          end else if (!rx_s) begin
            state    <= DATA;
            baud_cnt <= FULL_LOAD;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        DATA: begin
          if (baud_cnt != '0) begin
            baud_cnt <= baud_cnt - 1'b1;
          end else begin
            shreg    <= {rx_s, shreg[DATA_BITS-1:1]};
            baud_cnt <= FULL_LOAD;
            bit_cnt  <= bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT) begin
              state <= HAS_PAR ? PAR : STOP;
            end
          end
        end

        PAR: begin
          if (baud_cnt != '0) begin
            baud_cnt <= baud_cnt - 1'b1;
          end else begin
            par_err  <= ((^shreg) ^ rx_s) != ODD;
            baud_cnt <= FULL_LOAD;
            state    <= STOP;
          end
        end

        STOP: begin
          if (baud_cnt != '0) begin
            baud_cnt <= baud_cnt - 1'b1;
          end else begin
            rx_data <= shreg;
            rx_rdy  <= 1'b1;
            ferr    <= ~rx_s;
            perr    <= HAS_PAR && par_err;
            ovf     <= rx_rdy && !rd_ack;
            state   <= IDLE;
            busy    <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
